// File: rtl/sram_like_arbiter.sv
// Two-master (instruction fetch / load-store) to one SRAM-like memory port arbiter.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed data priority for alternating grant.
module sram_like_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        LOCK_NONE,
        LOCK_INST,
        LOCK_DATA
    } lock_t;

    lock_t            lock_state;
    lock_t            lock_next;
    logic [DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tag_full;
    logic             tag_empty;
    logic             mem_req_int;
    logic             grant_data;
    logic             push;
    logic             pop;
    logic             head_tag;

    assign tag_full    = (count == CNT_W'(DEPTH));
    assign tag_empty   = (count == '0);
    assign mem_req_int = (inst_req | data_req) & ~tag_full;
    assign push        = mem_req_int & mem_addr_ok;
    assign pop         = mem_data_ok & ~tag_empty;
    assign head_tag    = tag_mem[rd_ptr];

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_prefer_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_prefer_data <= 1'b1;
        end else if (push) begin
            rr_prefer_data <= ~grant_data;
        end
    end
`endif

    // A locked grant holds the stalled master until its request is taken.
    always_comb begin
        grant_data = 1'b0;
        case (lock_state)
            LOCK_INST: grant_data = 1'b0;
            LOCK_DATA: grant_data = 1'b1;
            default: begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_data = (inst_req & data_req) ? rr_prefer_data : data_req;
`else
                grant_data = data_req;
`endif
            end
        endcase
    end

    always_comb begin
        lock_next = lock_state;
        if (push) begin
            lock_next = LOCK_NONE;
        end else if (mem_req_int && !mem_addr_ok) begin
            lock_next = grant_data ? LOCK_DATA : LOCK_INST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state <= LOCK_NONE;
            tag_mem    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            lock_state <= lock_next;
            if (push) begin
                tag_mem[wr_ptr] <= grant_data;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Every output is forced low while reset is held.
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;
        if (!rst) begin
            mem_req = mem_req_int;
            if (grant_data) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
            inst_addr_ok = push & ~grant_data;
            data_addr_ok = push & grant_data;
            inst_data_ok = pop & ~head_tag;
            data_data_ok = pop & head_tag;
            inst_rdata   = mem_rdata;
            data_rdata   = mem_rdata;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter (DEPTH=4).
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_sram_like_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int  check_count = 0;
    int  error_count = 0;
    bit  rr_en;
    bit  exp_tags[$];
    bit  g;
    bit  head;

    sram_like_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [1:0] ds,
                                 input logic [31:0] da, input logic [31:0] dwd,
                                 input logic aok, input logic dok, input logic [31:0] rd);
        inst_req    = ir;
        inst_addr   = ia;
        data_req    = dr;
        data_wr     = dw;
        data_size   = ds;
        data_addr   = da;
        data_wdata  = dwd;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        rr_en = 1'b1;
`else
        rr_en = 1'b0;
`endif
        rst = 1'b1;
        applyStimulus(1, 32'h1000, 1, 0, 2, 32'h2000, 32'h0, 1, 1, 32'hDEAD);
        @(negedge clk);
        #1;
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_inst_aok", inst_addr_ok, 0);
        checkOutput("rst_data_aok", data_addr_ok, 0);
        checkOutput("rst_data_dok", data_data_ok, 0);
        checkOutput("rst_rdata", data_rdata, 0);
        idle();
        rst = 1'b0;
        @(negedge clk);

        // Both masters request from reset with memory always ready.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h1000 + i, 1, 0, 2, 32'h2000 + i, 32'h0, 1, 0, 0);
            #1;
            g = rr_en ? (i % 2 == 0) : 1'b1;
            checkOutput("both_data_aok", data_addr_ok, g);
            checkOutput("both_inst_aok", inst_addr_ok, !g);
            checkOutput("both_addr", mem_addr, g ? 32'h2000 + i : 32'h1000 + i);
            exp_tags.push_back(g);
            @(negedge clk);
        end
        applyStimulus(1, 32'h1004, 1, 0, 2, 32'h2004, 32'h0, 1, 0, 0);
        #1;
        checkOutput("full_mem_req", mem_req, 0);
        checkOutput("full_inst_aok", inst_addr_ok, 0);
        checkOutput("full_data_aok", data_addr_ok, 0);
        @(negedge clk);
        applyStimulus(1, 32'h1004, 1, 0, 2, 32'h2004, 32'h0, 1, 1, 32'h11);
        #1;
        head = exp_tags.pop_front();
        checkOutput("fullpop_mem_req", mem_req, 0);
        checkOutput("fullpop_data_dok", data_data_ok, head);
        checkOutput("fullpop_inst_dok", inst_data_ok, !head);
        checkOutput("fullpop_inst_rdata", inst_rdata, 32'h11);
        @(negedge clk);
        applyStimulus(1, 32'h1004, 1, 0, 2, 32'h2004, 32'h0, 1, 0, 0);
        #1;
        checkOutput("afterpop_mem_req", mem_req, 1);
        checkOutput("afterpop_data_aok", data_addr_ok, 1);
        exp_tags.push_back(1'b1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20 + i);
            #1;
            head = exp_tags.pop_front();
            checkOutput("drain_data_dok", data_data_ok, head);
            checkOutput("drain_inst_dok", inst_data_ok, !head);
            checkOutput("drain_rdata", data_rdata, 32'h20 + i);
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
        #1;
        checkOutput("empty_data_dok", data_data_ok, 0);
        checkOutput("empty_inst_dok", inst_data_ok, 0);
        @(negedge clk);

        // Stalled fetch keeps its grant while data starts requesting.
        doReset();
        applyStimulus(1, 32'h1FC00000, 0, 0, 0, 32'h100, 32'hCAFE, 0, 0, 0);
        #1;
        checkOutput("lock_mem_req", mem_req, 1);
        checkOutput("lock_addr0", mem_addr, 32'h1FC00000);
        checkOutput("lock_size", mem_size, 2);
        checkOutput("lock_wr", mem_wr, 0);
        @(negedge clk);
        applyStimulus(1, 32'h1FC00000, 1, 1, 0, 32'h100, 32'hCAFE, 0, 0, 0);
        #1;
        checkOutput("lock_addr1", mem_addr, 32'h1FC00000);
        checkOutput("lock_wdata", mem_wdata, 0);
        checkOutput("lock_wr1", mem_wr, 0);
        @(negedge clk);
        applyStimulus(1, 32'h1FC00000, 1, 1, 0, 32'h100, 32'hCAFE, 1, 0, 0);
        #1;
        checkOutput("lock_addr2", mem_addr, 32'h1FC00000);
        checkOutput("lock_inst_aok", inst_addr_ok, 1);
        checkOutput("lock_data_aok", data_addr_ok, 0);
        @(negedge clk);
        applyStimulus(1, 32'h1FC00004, 1, 1, 0, 32'h100, 32'hCAFE, 1, 0, 0);
        #1;
        checkOutput("lock_next_data_aok", data_addr_ok, 1);
        checkOutput("lock_next_addr", mem_addr, 32'h100);
        @(negedge clk);

        // Byte store passes through unchanged.
        doReset();
        applyStimulus(0, 0, 1, 1, 0, 32'h80000003, 32'h55, 1, 0, 0);
        #1;
        checkOutput("store_wr", mem_wr, 1);
        checkOutput("store_size", mem_size, 0);
        checkOutput("store_addr", mem_addr, 32'h80000003);
        checkOutput("store_wdata", mem_wdata, 32'h55);
        checkOutput("store_aok", data_addr_ok, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        checkOutput("store_dok", data_data_ok, 1);
        checkOutput("store_inst_dok", inst_data_ok, 0);
        @(negedge clk);

        // Responses are steered by recorded order: inst, data, inst.
        doReset();
        applyStimulus(1, 32'h3000, 0, 0, 2, 0, 0, 1, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 1, 0, 2, 32'h4000, 0, 1, 0, 0);
        @(negedge clk);
        applyStimulus(1, 32'h3004, 0, 0, 2, 0, 0, 1, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA + i);
            #1;
            checkOutput("order_inst_dok", inst_data_ok, (i != 1));
            checkOutput("order_data_dok", data_data_ok, (i == 1));
            checkOutput("order_rdata", inst_rdata, 32'hA + i);
            @(negedge clk);
        end

        // Reset with two outstanding discards them.
        doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1, 0, 2, 32'h5000 + i, 0, 1, 0, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        applyStimulus(1, 32'h6000, 1, 0, 2, 32'h5002, 0, 1, 1, 32'h77);
        #1;
        checkOutput("midrst_mem_req", mem_req, 0);
        checkOutput("midrst_mem_addr", mem_addr, 0);
        checkOutput("midrst_data_dok", data_data_ok, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        #1;
        checkOutput("stray_data_dok", data_data_ok, 0);
        checkOutput("stray_inst_dok", inst_data_ok, 0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 2, 32'h7000 + i, 0, 1, 0, 0);
            #1;
            checkOutput("refill_data_aok", data_addr_ok, 1);
            @(negedge clk);
        end
        applyStimulus(0, 0, 1, 0, 2, 32'h7004, 0, 1, 0, 0);
        #1;
        checkOutput("refill_full_mem_req", mem_req, 0);
        @(negedge clk);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 DEPTH, default 4, maximum outstanding accepted-but-unanswered transactions; power of two, 2..16.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 inst_req  in  1  instruction fetch request (read-only master).
REQ-005 inst_addr  in  32  fetch address.
REQ-006 inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-007 inst_data_ok  out  1  fetch data valid this cycle.
REQ-008 inst_rdata  out  32  fetch data.
REQ-009 data_req  in  1  load/store request.
REQ-010 data_wr  in  1  1=store, 0=load.
REQ-011 data_size  in  2  0=byte, 1=half, 2=word.
REQ-012 data_addr  in  32  load/store address.
REQ-013 data_wdata  in  32  store data.
REQ-014 data_addr_ok  out  1  load/store request accepted this cycle.
REQ-015 data_data_ok  out  1  load data valid or store complete this cycle.
REQ-016 data_rdata  out  32  load data.
REQ-017 mem_req, mem_wr, mem_size[2], mem_addr[32], mem_wdata[32]  out  merged SRAM-like request to memory side.
REQ-018 mem_addr_ok, mem_data_ok  in  1  memory-side handshakes; mem_rdata  in  32  memory-side read data.

Function
REQ-019 Request accepted only in a cycle with mem_req=1 and mem_addr_ok=1 (push).
REQ-020 mem_req = (inst_req | data_req) & ~tag_full; mem_wr/size/addr/wdata are the granted master's fields; inst grant drives mem_wr=0, mem_size=2, mem_wdata=0.
REQ-021 Grant lock: once mem_req=1 without mem_addr_ok, the granted master stays granted until its push; lock clears at push.
REQ-022 Unlocked grant (macro absent): data before inst.
REQ-023 mem_addr_ok routes only to the granted master's addr_ok; the other master's addr_ok = 0.
REQ-024 Tag FIFO (DEPTH entries, 1 bit: 0=inst, 1=data) records master of each push, in order.
REQ-025 Each mem_data_ok pops head; asserts inst_data_ok or data_data_ok per head tag, same cycle (combinational); mem_rdata fans out to both rdata outputs.
REQ-026 tag_full: mem_req=0, both addr_ok=0; a pop in the same cycle does not enable a push.
REQ-027 Simultaneous push and pop when not full: both take effect; count unchanged.
REQ-028 mem_data_ok with FIFO empty: ignored; both data_ok=0; no state change.
REQ-029 FIFO pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-030 Latency: zero added cycles on request and response paths.

Reset
REQ-031 On rst: FIFO empty, pointers 0, lock clear, round-robin pointer = data; all outputs combinationally 0 while rst high.
REQ-032 rst mid-transaction discards outstanding tags; later stray mem_data_ok handled per REQ-028.

Configuration
REQ-033 ARB_ROUND_ROBIN_EN defined: unlocked grant alternates; after a data push, inst preferred next, and vice versa; a lone requester always granted.
REQ-034 ARB_ROUND_ROBIN_EN undefined: fixed data priority per REQ-022; no round-robin state.

Verification
REQ-035 Both req=1 from reset, mem_addr_ok=1 for 4 cycles -> without macro: 4 data pushes, inst_addr_ok=0; with macro: data, inst, data, inst.
REQ-036 inst_req=1 at 0x1FC00000, mem_addr_ok=0 2 cycles; data_req=1 in cycle 1 -> mem_addr stays 0x1FC00000 until push; data granted next.
REQ-037 DEPTH=4, 4 pushes, no mem_data_ok -> mem_req=0 and both addr_ok=0 while both req=1; one mem_data_ok -> push only next cycle.
REQ-038 Push inst, data, inst; mem_data_ok 3 cycles, mem_rdata 0xA, 0xB, 0xC -> inst_data_ok/0xA, data_data_ok/0xB, inst_data_ok/0xC.
REQ-039 Store, data_size=0, addr 0x80000003, wdata 0x55 -> mem_wr=1, mem_size=0, same addr/wdata; mem_data_ok -> data_data_ok=1.
REQ-040 rst asserted with 2 outstanding, then mem_data_ok pulse -> both data_ok=0; FIFO count 0.
